// File: rtl/clock_scalar_ctrl_if.sv
// Command handshake between a requester and the clock scalar controller.
interface clock_scalar_ctrl_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_scalar;
  logic       cmd_en;

  modport master (output cmd_valid, output cmd_scalar, output cmd_en, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_scalar, input cmd_en, output cmd_ready);
endinterface

// File: rtl/clock_scalar_ctrl.sv
// Clock generator divider update sequencer: program, strobe, verify by readback, settle.
module clock_scalar_ctrl #(
  parameter int unsigned SETTLE_EXTRA = 2,
  parameter int unsigned MAX_RETRY    = 3
) (
  input  logic                      clk_inp,
  input  logic                      rst,
  clock_scalar_ctrl_if.slave        cmd,
  output logic                      gen_en,
  output logic [7:0]                gen_scalar_inp,
  output logic                      gen_scalar_write,
  input  logic [7:0]                gen_scalar_oup,
  output logic [7:0]                cur_scalar,
  output logic                      busy,
  output logic                      done,
  output logic                      err
);

  localparam int unsigned RETRY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam int unsigned CNT_W   = 9;
  localparam logic [RETRY_W-1:0] MAX_RETRY_V = RETRY_W'(MAX_RETRY);
  localparam logic [CNT_W-1:0]   EXTRA_V     = CNT_W'(SETTLE_EXTRA);

  typedef enum logic [2:0] {
    ST_IDLE, ST_SETUP, ST_STROBE, ST_CHECK, ST_SETTLE, ST_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [7:0]         scalar_q, scalar_d;
  logic               en_q, en_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               phase_q, phase_d;
  logic               gen_en_d, write_d, done_d, err_d;
  logic [7:0]         inp_d, cur_d;

  assign cmd.cmd_ready = (state_q == ST_IDLE) && !rst;
  assign busy          = (state_q != ST_IDLE);

  // Next-state and next registered-output values.
  always_comb begin
    state_d  = state_q;
    scalar_d = scalar_q;
    en_d     = en_q;
    retry_d  = retry_q;
    cnt_d    = cnt_q;
    phase_d  = phase_q;
    gen_en_d = gen_en;
    inp_d    = gen_scalar_inp;
    write_d  = 1'b0;
    cur_d    = cur_scalar;
    done_d   = 1'b0;
    err_d    = err;
    case (state_q)
      ST_IDLE: begin
        if (cmd.cmd_valid) begin
          scalar_d = cmd.cmd_scalar;
          en_d     = cmd.cmd_en;
          retry_d  = '0;
          err_d    = 1'b0;
          gen_en_d = 1'b1;
          inp_d    = cmd.cmd_scalar;
          state_d  = ST_SETUP;
        end
      end
      ST_SETUP: begin
        write_d = 1'b1;
        phase_d = 1'b0;
        state_d = ST_STROBE;
      end
      ST_STROBE: begin
        if (!phase_q) begin
          phase_d = 1'b1;
          write_d = 1'b1;
        end else begin
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (gen_scalar_oup == scalar_q) begin
          cnt_d   = {1'b0, scalar_q} + EXTRA_V;
          state_d = ST_SETTLE;
        end else if (retry_q < MAX_RETRY_V) begin
          retry_d = retry_q + RETRY_W'(1);
          state_d = ST_SETUP;
        end else begin
          err_d    = 1'b1;
          gen_en_d = 1'b0;
          state_d  = ST_IDLE;
        end
      end
      ST_SETTLE: begin
        if (cnt_q == '0) begin
          done_d  = 1'b1;
          cur_d   = scalar_q;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_DONE: begin
        gen_en_d = en_q;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; reset aborts any sequence on the same edge.
  always_ff @(posedge clk_inp) begin
    if (rst) begin
      state_q          <= ST_IDLE;
      scalar_q         <= '0;
      en_q             <= 1'b0;
      retry_q          <= '0;
      cnt_q            <= '0;
      phase_q          <= 1'b0;
      gen_en           <= 1'b0;
      gen_scalar_inp   <= '0;
      gen_scalar_write <= 1'b0;
      cur_scalar       <= '0;
      done             <= 1'b0;
      err              <= 1'b0;
    end else begin
      state_q          <= state_d;
      scalar_q         <= scalar_d;
      en_q             <= en_d;
      retry_q          <= retry_d;
      cnt_q            <= cnt_d;
      phase_q          <= phase_d;
      gen_en           <= gen_en_d;
      gen_scalar_inp   <= inp_d;
      gen_scalar_write <= write_d;
      cur_scalar       <= cur_d;
      done             <= done_d;
      err              <= err_d;
    end
  end

endmodule
